// File: rtl/tx_seq_frp_insert_pkg.sv
// tx_seq_frp_insert_pkg: shared word geometry, tail link field layout and flow command helpers
package tx_seq_frp_insert_pkg;
    localparam int LOG_FPW   = 2;
    localparam int FPW       = 1 << LOG_FPW;
    localparam int FLIT_W    = 128;
    localparam int DWIDTH    = FPW * FLIT_W;
    localparam int RRP_LO    = 64;
    localparam int FRP_LO    = 72;
    localparam int SEQ_LO    = 80;
    localparam int RTC_LO    = 91;
    localparam int RTC_MAX   = 31;
    localparam int TOK_CNT_W = 10;
    localparam logic [5:0] CMD_PRET  = 6'h01;
    localparam logic [5:0] CMD_IRTRY = 6'h03;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef struct packed {
        logic [7:0] rrp;
        logic [7:0] frp;
        logic [2:0] seq;
        logic [4:0] rtc;
    } tail_fld_t;

    function automatic logic [5:0] cmd(input flit_t f);
        return f[5:0];
    endfunction

    function automatic logic is_flow(input flit_t f);
        return cmd(f) == CMD_PRET || cmd(f) == CMD_IRTRY;
    endfunction

    function automatic flit_t ins_fields(input flit_t f, input tail_fld_t t);
        flit_t r;
        r = f;
        r[RRP_LO +: 8] = t.rrp;
        r[FRP_LO +: 8] = t.frp;
        r[SEQ_LO +: 3] = t.seq;
        r[RTC_LO +: 5] = t.rtc;
        return r;
    endfunction
endpackage

// File: rtl/tx_seq_frp_insert_if.sv
// tx_seq_frp_insert_if: FPW-flit word bus (per-flit valid/header/tail flags plus data)
interface tx_seq_frp_insert_if;
    import tx_seq_frp_insert_pkg::*;
    logic [FPW-1:0]    valid;
    logic [FPW-1:0]    hdr;
    logic [FPW-1:0]    tail;
    logic [DWIDTH-1:0] data;
    modport master (output valid, hdr, tail, data);
    modport slave  (input  valid, hdr, tail, data);
endinterface

// File: rtl/tx_seq_frp_insert_tail_field_calc.sv
// tx_tail_field_calc: ascending prefix walk over the word assigning SEQ/FRP/RTC to each tail
module tx_tail_field_calc import tx_seq_frp_insert_pkg::*; (
    input  logic [FPW-1:0]       valid_i,
    input  logic [FPW-1:0]       hdr_i,
    input  logic [FPW-1:0]       tail_i,
    input  logic [FPW-1:0]       flow_i,
    input  logic                 in_flow_i,
    input  logic [2:0]           seq_cnt_i,
    input  logic [7:0]           frp_ptr_i,
    input  logic [7:0]           rrp_i,
    input  logic [TOK_CNT_W-1:0] tok_cnt_i,
    output logic [FPW-1:0]       rb_we_o,
    output logic [FPW-1:0]       ins_o,
    output tail_fld_t            fld_o [FPW],
    output logic                 in_flow_o,
    output logic [2:0]           seq_cnt_o,
    output logic [7:0]           frp_ptr_o,
    output logic [TOK_CNT_W-1:0] rtc_sum_o
);
    logic                 open;
    logic                 flow_hdr;
    logic                 nf;
    logic [4:0]           rtc;
    logic [TOK_CNT_W-1:0] avail;

    // A valid flit belongs to a non-flow packet if it opens one or continues an open one.
    always_comb begin
        open      = in_flow_i;
        seq_cnt_o = seq_cnt_i;
        frp_ptr_o = frp_ptr_i;
        avail     = tok_cnt_i;
        rtc_sum_o = '0;
        rb_we_o   = '0;
        ins_o     = '0;
        flow_hdr  = 1'b0;
        nf        = 1'b0;
        rtc       = '0;
        for (int f = 0; f < FPW; f++) begin
            flow_hdr   = valid_i[f] & hdr_i[f] & flow_i[f];
            nf         = valid_i[f] & ~flow_hdr & (hdr_i[f] | open);
            rtc        = (avail > TOK_CNT_W'(RTC_MAX)) ? 5'(RTC_MAX) : avail[4:0];
            fld_o[f]   = '{rrp: rrp_i,
                           frp: nf ? frp_ptr_o : 8'h0,
                           seq: nf ? seq_cnt_o : 3'h0,
                           rtc: nf ? rtc : 5'h0};
            rb_we_o[f] = nf;
            ins_o[f]   = flow_hdr | (nf & tail_i[f]);
            if (nf & tail_i[f]) begin
                seq_cnt_o = seq_cnt_o + 3'd1;
                avail     = avail - TOK_CNT_W'(rtc);
                rtc_sum_o = rtc_sum_o + TOK_CNT_W'(rtc);
            end
            if (nf) begin
                frp_ptr_o = frp_ptr_o + 8'd1;
                open      = ~tail_i[f];
            end
        end
        in_flow_o = open;
    end
endmodule

// File: rtl/tx_seq_frp_insert.sv
// tx_seq_frp_insert: inserts RRP/FRP/SEQ/RTC into tail flits and drives retry-buffer write strobes
module tx_seq_frp_insert import tx_seq_frp_insert_pkg::*; (
    input  logic                 clk,
    input  logic                 res_n,
    tx_seq_frp_insert_if.slave   d_in,
    tx_seq_frp_insert_if.master  d_out,
    input  logic [7:0]           rrp_in,
    input  logic [7:0]           tokens_in,
    output logic [FPW-1:0]       rb_we,
    output logic [7:0]           rb_base_addr,
    output logic [TOK_CNT_W-1:0] tokens_pending
);
    logic [2:0]           seq_cnt_q, seq_cnt_d;
    logic [7:0]           frp_ptr_q, frp_ptr_d;
    logic [TOK_CNT_W-1:0] tok_cnt_q, tok_cnt_d;
    logic                 in_flow_q, in_flow_d;
    logic [7:0]           rrp_q;
    logic [FPW-1:0]       flow, ins, we_d;
    tail_fld_t            fld [FPW];
    logic [TOK_CNT_W-1:0] rtc_sum;
    logic [TOK_CNT_W:0]   tok_sum;
    logic [DWIDTH-1:0]    data_d;

    always_comb begin
        for (int f = 0; f < FPW; f++) flow[f] = is_flow(d_in.data[f*FLIT_W +: FLIT_W]);
    end

    tx_tail_field_calc u_calc (
        .valid_i   (d_in.valid),
        .hdr_i     (d_in.hdr),
        .tail_i    (d_in.tail),
        .flow_i    (flow),
        .in_flow_i (in_flow_q),
        .seq_cnt_i (seq_cnt_q),
        .frp_ptr_i (frp_ptr_q),
        .rrp_i     (rrp_q),
        .tok_cnt_i (tok_cnt_q),
        .rb_we_o   (we_d),
        .ins_o     (ins),
        .fld_o     (fld),
        .in_flow_o (in_flow_d),
        .seq_cnt_o (seq_cnt_d),
        .frp_ptr_o (frp_ptr_d),
        .rtc_sum_o (rtc_sum)
    );

    always_comb begin
        for (int f = 0; f < FPW; f++)
            data_d[f*FLIT_W +: FLIT_W] = ins[f] ? ins_fields(d_in.data[f*FLIT_W +: FLIT_W], fld[f])
                                                : d_in.data[f*FLIT_W +: FLIT_W];
    end

    // Returned RTC never exceeds tok_cnt_q, so the sum stays non-negative; only the upper bound saturates.
    assign tok_sum   = {1'b0, tok_cnt_q} - {1'b0, rtc_sum} + {3'b0, tokens_in};
    assign tok_cnt_d = tok_sum[TOK_CNT_W] ? '1 : tok_sum[TOK_CNT_W-1:0];

    assign tokens_pending = tok_cnt_q;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            seq_cnt_q    <= '0;
            frp_ptr_q    <= '0;
            tok_cnt_q    <= '0;
            in_flow_q    <= 1'b0;
            rrp_q        <= '0;
            d_out.valid  <= '0;
            d_out.hdr    <= '0;
            d_out.tail   <= '0;
            d_out.data   <= '0;
            rb_we        <= '0;
            rb_base_addr <= '0;
        end else begin
            seq_cnt_q    <= seq_cnt_d;
            frp_ptr_q    <= frp_ptr_d;
            tok_cnt_q    <= tok_cnt_d;
            in_flow_q    <= in_flow_d;
            rrp_q        <= rrp_in;
            d_out.valid  <= d_in.valid;
            d_out.hdr    <= d_in.hdr;
            d_out.tail   <= d_in.tail;
            d_out.data   <= data_d;
            rb_we        <= we_d;
            rb_base_addr <= frp_ptr_q;
        end
    end
endmodule

// File: tb/tb_tx_seq_frp_insert.sv
// tb_tx_seq_frp_insert: directed scoreboard bench for the tail-field inserter
module tb_tx_seq_frp_insert;
    import tx_seq_frp_insert_pkg::*;

    localparam logic [5:0] WR = 6'h08;

    logic       clk = 1'b0;
    logic       res_n = 1'b0;
    logic [7:0] rrp_in = '0;
    logic [7:0] tokens_in = '0;
    logic [3:0] rb_we;
    logic [7:0] rb_base_addr;
    logic [9:0] tokens_pending;

    tx_seq_frp_insert_if d_in_if ();
    tx_seq_frp_insert_if d_out_if ();

    tx_seq_frp_insert dut (
        .clk            (clk),
        .res_n          (res_n),
        .d_in           (d_in_if),
        .d_out          (d_out_if),
        .rrp_in         (rrp_in),
        .tokens_in      (tokens_in),
        .rb_we          (rb_we),
        .rb_base_addr   (rb_base_addr),
        .tokens_pending (tokens_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   v, h, t;
        logic [511:0] data;
        logic [3:0]   we;
        logic [7:0]   base;
        logic [9:0]   pend;
        bit           chk;
    } exp_t;

    exp_t         sb [$];
    int           n_vec = 0;
    int           n_err = 0;
    logic [127:0] fi [4];
    logic [127:0] fo [4];

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] put(input logic [127:0] f, input logic [7:0] rrp, input logic [7:0] frp,
                                         input logic [2:0] seq, input logic [4:0] rtc);
        logic [127:0] r;
        r = f;
        r[71:64] = rrp;
        r[79:72] = frp;
        r[82:80] = seq;
        r[95:91] = rtc;
        return r;
    endfunction

    task automatic flits(input logic [3:0] v, input logic [5:0] c);
        for (int f = 0; f < 4; f++) begin
            fi[f] = v[f] ? {$urandom(), $urandom(), $urandom(), $urandom()} : 128'h0;
            if (v[f]) fi[f][5:0] = c;
            fo[f] = fi[f];
        end
    endtask

    task automatic run(input logic [3:0] v, input logic [3:0] h, input logic [3:0] t, input logic [7:0] rrp,
                       input logic [7:0] tok, input logic [7:0] base, input logic [3:0] we,
                       input logic [9:0] pend, input bit chk);
        exp_t e;
        e.v = v; e.h = h; e.t = t;
        e.data = {fo[3], fo[2], fo[1], fo[0]};
        e.we = we; e.base = base; e.pend = pend; e.chk = chk;
        @(negedge clk);
        d_in_if.valid = v;
        d_in_if.hdr   = h;
        d_in_if.tail  = t;
        d_in_if.data  = {fi[3], fi[2], fi[1], fi[0]};
        rrp_in        = rrp;
        tokens_in     = tok;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("valid", 512'(d_out_if.valid), 512'(e.v));
        check("hdr", 512'(d_out_if.hdr), 512'(e.h));
        check("tail", 512'(d_out_if.tail), 512'(e.t));
        if (e.chk) check("data", d_out_if.data, e.data);
        check("rb_we", 512'(rb_we), 512'(e.we));
        check("rb_base_addr", 512'(rb_base_addr), 512'(e.base));
        check("tokens_pending", 512'(tokens_pending), 512'(e.pend));
    endtask

    task automatic idle(input logic [7:0] rrp, input logic [7:0] tok, input logic [7:0] base, input logic [9:0] pend);
        flits(4'b0000, WR);
        run(4'b0000, 4'b0000, 4'b0000, rrp, tok, base, 4'b0000, pend, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        res_n         = 1'b0;
        d_in_if.valid = '0;
        d_in_if.hdr   = '0;
        d_in_if.tail  = '0;
        d_in_if.data  = '0;
        #1;
        check("rst_valid", 512'(d_out_if.valid), 512'(0));
        check("rst_data", d_out_if.data, 512'(0));
        check("rst_rb_we", 512'(rb_we), 512'(0));
        check("rst_base", 512'(rb_base_addr), 512'(0));
        check("rst_pend", 512'(tokens_pending), 512'(0));
        @(negedge clk);
        res_n = 1'b1;
    endtask

    initial begin
        d_in_if.valid = '0;
        d_in_if.hdr   = '0;
        d_in_if.tail  = '0;
        d_in_if.data  = '0;
        do_reset();
        repeat (10) idle(8'h00, 8'd0, 8'd0, 10'd0);
        // single-flit write with 5 tokens banked and RRP 2A
        idle(8'h2A, 8'd5, 8'd0, 10'd5);
        flits(4'b0001, WR);
        fo[0] = put(fi[0], 8'h2A, 8'd0, 3'd0, 5'd5);
        run(4'b0001, 4'b0001, 4'b0001, 8'h2A, 8'd0, 8'd0, 4'b0001, 10'd0, 1'b1);
        // open a packet, then reset in the middle of it
        flits(4'b1000, WR);
        run(4'b1000, 4'b1000, 4'b0000, 8'h2A, 8'd0, 8'd1, 4'b1000, 10'd0, 1'b1);
        do_reset();
        // 3-flit packet spanning two words
        flits(4'b1100, WR);
        run(4'b1100, 4'b0100, 4'b0000, 8'h2A, 8'd0, 8'd0, 4'b1100, 10'd0, 1'b1);
        flits(4'b0001, WR);
        fo[0] = put(fi[0], 8'h2A, 8'd2, 3'd0, 5'd0);
        run(4'b0001, 4'b0000, 4'b0001, 8'h2A, 8'd0, 8'd2, 4'b0001, 10'd0, 1'b1);
        do_reset();
        // PRET between two single-flit writes
        idle(8'h3C, 8'd0, 8'd0, 10'd0);
        flits(4'b0111, WR);
        fi[1][5:0] = CMD_PRET;
        fo[0] = put(fi[0], 8'h3C, 8'd0, 3'd0, 5'd0);
        fo[1] = put(fi[1], 8'h3C, 8'd0, 3'd0, 5'd0);
        fo[2] = put(fi[2], 8'h3C, 8'd1, 3'd1, 5'd0);
        run(4'b0111, 4'b0111, 4'b0111, 8'h3C, 8'd0, 8'd0, 4'b0101, 10'd0, 1'b1);
        do_reset();
        // advance to frp_ptr=254, seq_cnt=7: six single writes plus one 248-flit packet
        flits(4'b1111, WR);
        run(4'b1111, 4'b1111, 4'b1111, 8'h77, 8'd0, 8'd0, 4'b1111, 10'd0, 1'b0);
        flits(4'b0011, WR);
        run(4'b0011, 4'b0011, 4'b0011, 8'h77, 8'd0, 8'd4, 4'b0011, 10'd0, 1'b0);
        for (int k = 0; k < 62; k++) begin
            flits(4'b1111, WR);
            run(4'b1111, (k == 0) ? 4'b0001 : 4'b0000, (k == 61) ? 4'b1000 : 4'b0000, 8'h77, 8'd0,
                8'(6 + 4 * k), 4'b1111, 10'd0, 1'b0);
        end
        // pointer and sequence wrap; tokens arriving now are not yet returnable
        flits(4'b1111, WR);
        fo[0] = put(fi[0], 8'h77, 8'd254, 3'd7, 5'd0);
        fo[1] = put(fi[1], 8'h77, 8'd255, 3'd0, 5'd0);
        fo[2] = put(fi[2], 8'h77, 8'd0, 3'd1, 5'd0);
        fo[3] = put(fi[3], 8'h77, 8'd1, 3'd2, 5'd0);
        run(4'b1111, 4'b1111, 4'b1111, 8'h77, 8'd40, 8'd254, 4'b1111, 10'd40, 1'b1);
        // 40 tokens split over two tails
        flits(4'b0011, WR);
        fo[0] = put(fi[0], 8'h77, 8'd2, 3'd3, 5'd31);
        fo[1] = put(fi[1], 8'h77, 8'd3, 3'd4, 5'd9);
        run(4'b0011, 4'b0011, 4'b0011, 8'h77, 8'd3, 8'd2, 4'b0011, 10'd3, 1'b1);
        idle(8'h77, 8'd255, 8'd4, 10'd258);
        idle(8'h77, 8'd255, 8'd4, 10'd513);
        idle(8'h77, 8'd255, 8'd4, 10'd768);
        idle(8'h77, 8'd255, 8'd4, 10'd1023);
        idle(8'h77, 8'd255, 8'd4, 10'd1023);
        idle(8'h77, 8'd0, 8'd4, 10'd1023);
        // IRTRY gets no tokens; the following write takes the capped 31
        flits(4'b0011, WR);
        fi[0][5:0] = CMD_IRTRY;
        fo[0] = put(fi[0], 8'h77, 8'd0, 3'd0, 5'd0);
        fo[1] = put(fi[1], 8'h77, 8'd4, 3'd5, 5'd31);
        run(4'b0011, 4'b0011, 4'b0011, 8'h77, 8'd0, 8'd4, 4'b0010, 10'd992, 1'b1);
        idle(8'h77, 8'd0, 8'd5, 10'd992);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
